i2c_line_frontend: RTL and testbench

Pad-side conditioning stage that sits directly upstream of the I2C slave. It takes raw `SCL_in`/`SDA_in` from `io_in[1:0]`, synchronizes and de-glitches both lines, and produces clean levels plus single-cycle SCL edge, START and STOP strobes. It also tracks bus ownership, so the slave logic works only from filtered, clock-domain-safe events.

---
 rtl/i2c_pkg.sv | 18 +
 rtl/i2c_line_frontend_if.sv | 42 ++++
 rtl/i2c_line_filt.sv | 71 +++++++
 rtl/i2c_line_frontend.sv | 107 ++++++++++
 tb/tb_i2c_line_frontend.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg
// Shared types and default constants for the I2C line front end.
//   bus_state_t     : bus ownership state (BUS_IDLE / BUS_BUSY)
//   I2C_SYNC_STAGES : default synchronizer depth per line
//   I2C_FILT_LEN    : default number of differing samples needed to accept a level
//   GLITCH_CNT_W    : width of the optional rejected-glitch counter
package i2c_pkg;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_BUSY = 1'b1
  } bus_state_t;

  localparam int I2C_SYNC_STAGES = 2;
  localparam int I2C_FILT_LEN    = 3;
  localparam int GLITCH_CNT_W    = 8;

endpackage

// File: rtl/i2c_line_frontend_if.sv
// i2c_line_frontend_if
// Bundles the raw pad inputs and the conditioned outputs of the I2C line front end.
//   SCL_in, SDA_in         : raw pad levels (driven by the pad side)
//   scl_filt, sda_filt     : filtered levels
//   scl_rise, scl_fall     : one-cycle filtered SCL edge strobes
//   start_det, stop_det    : one-cycle START / STOP strobes
//   bus_busy               : high between START and STOP
//   glitch_cnt             : saturating rejected-glitch count, only with I2C_GLITCH_COUNT_EN
// Modports: master = pad/consumer side, slave = the front end itself.
interface i2c_line_frontend_if;
  import i2c_pkg::*;

  logic SCL_in;
  logic SDA_in;
  logic scl_filt;
  logic sda_filt;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;
  logic bus_busy;
`ifdef I2C_GLITCH_COUNT_EN
  logic [GLITCH_CNT_W-1:0] glitch_cnt;
`endif

  modport master (
    output SCL_in, SDA_in,
    input  scl_filt, sda_filt, scl_rise, scl_fall, start_det, stop_det, bus_busy
`ifdef I2C_GLITCH_COUNT_EN
    , input glitch_cnt
`endif
  );

  modport slave (
    input  SCL_in, SDA_in,
    output scl_filt, sda_filt, scl_rise, scl_fall, start_det, stop_det, bus_busy
`ifdef I2C_GLITCH_COUNT_EN
    , output glitch_cnt
`endif
  );

endinterface

// File: rtl/i2c_line_filt.sv
// i2c_line_filt
// One I2C line: synchronizer chain, run-length de-glitch filter and history register.
//   clock     : system clock
//   reset     : asynchronous, active-low reset
//   line_in   : raw pad level
//   filt      : filtered level
//   filt_q    : filtered level one cycle earlier
//   filt_next : value filt takes at the next rising edge
//   glitch    : high for one cycle when a differing run ends without a flip
//               (port exists only with I2C_GLITCH_COUNT_EN)
module i2c_line_filt
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = I2C_SYNC_STAGES,
  parameter int FILT_LEN    = I2C_FILT_LEN
) (
  input  logic clock,
  input  logic reset,
  input  logic line_in,
  output logic filt,
  output logic filt_q,
  output logic filt_next
`ifdef I2C_GLITCH_COUNT_EN
  , output logic glitch
`endif
);

  localparam int CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_next;
  logic                   line_sync;
  logic                   differs;
  logic                   flip;

  assign line_sync = sync_q[SYNC_STAGES-1];
  assign differs   = (line_sync != filt);
  // The counter holds the number of differing samples already seen, so the
  // FILT_LEN-th consecutive differing sample is the one that flips the level.
  assign flip      = differs && (cnt_q == CNT_W'(FILT_LEN - 1));
  assign filt_next = filt ^ flip;

`ifdef I2C_GLITCH_COUNT_EN
  assign glitch = !differs && (cnt_q != '0);
`endif

  // Counter clears on agreement or on a flip, otherwise it extends the run.
  always_comb begin
    cnt_next = '0;
    if (differs && !flip) begin
      cnt_next = cnt_q + CNT_W'(1);
    end
  end

  // Synchronizer, filter state and the one-cycle history of the filtered level.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= '1;
      cnt_q  <= '0;
      filt   <= 1'b1;
      filt_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], line_in};
      cnt_q  <= cnt_next;
      filt   <= filt_next;
      filt_q <= filt;
    end
  end

endmodule

// File: rtl/i2c_line_frontend.sv
// i2c_line_frontend
// Pad-side conditioning for an I2C slave: synchronizes and de-glitches SCL/SDA,
// produces SCL edge, START and STOP strobes and tracks bus ownership.
//   clock : system clock
//   reset : asynchronous, active-low reset
//   bus   : i2c_line_frontend_if.slave (pads in, conditioned levels/strobes out)
// Optional feature: define I2C_GLITCH_COUNT_EN to add the saturating glitch_cnt output.
module i2c_line_frontend
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = I2C_SYNC_STAGES,
  parameter int FILT_LEN    = I2C_FILT_LEN
) (
  input  logic                 clock,
  input  logic                 reset,
  i2c_line_frontend_if.slave   bus
);

  logic scl_filt, scl_filt_q, scl_next;
  logic sda_filt, sda_filt_q, sda_next;
  logic start_next, stop_next;
  bus_state_t state_q, state_next;

`ifdef I2C_GLITCH_COUNT_EN
  logic                    scl_glitch, sda_glitch;
  logic [GLITCH_CNT_W-1:0] glitch_cnt_q;
  logic [GLITCH_CNT_W:0]   glitch_sum;
`endif

  i2c_line_filt #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_scl_filt (
    .clock     (clock),
    .reset     (reset),
    .line_in   (bus.SCL_in),
    .filt      (scl_filt),
    .filt_q    (scl_filt_q),
    .filt_next (scl_next)
`ifdef I2C_GLITCH_COUNT_EN
    , .glitch  (scl_glitch)
`endif
  );

  i2c_line_filt #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sda_filt (
    .clock     (clock),
    .reset     (reset),
    .line_in   (bus.SDA_in),
    .filt      (sda_filt),
    .filt_q    (sda_filt_q),
    .filt_next (sda_next)
`ifdef I2C_GLITCH_COUNT_EN
    , .glitch  (sda_glitch)
`endif
  );

  // Requiring SCL stable high across the SDA change means a simultaneous
  // SCL/SDA flip can only ever produce the SCL strobe.
  assign bus.scl_filt  = scl_filt;
  assign bus.sda_filt  = sda_filt;
  assign bus.scl_rise  = scl_filt & ~scl_filt_q;
  assign bus.scl_fall  = ~scl_filt & scl_filt_q;
  assign bus.start_det = scl_filt & scl_filt_q & ~sda_filt & sda_filt_q;
  assign bus.stop_det  = scl_filt & scl_filt_q & sda_filt & ~sda_filt_q;
  assign bus.bus_busy  = (state_q == BUS_BUSY);

  // The strobes only become visible after the filters flip, so the FSM looks
  // one edge ahead at the filter next-values; that lets bus_busy move in the
  // same cycle as start_det / stop_det.
  assign start_next = scl_next & scl_filt & ~sda_next & sda_filt;
  assign stop_next  = scl_next & scl_filt & sda_next & ~sda_filt;

  // Bus ownership state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= BUS_IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  // Repeated START keeps BUS_BUSY; a STOP while idle leaves the bus idle.
  always_comb begin
    state_next = state_q;
    unique case (state_q)
      BUS_IDLE: if (start_next) state_next = BUS_BUSY;
      BUS_BUSY: if (stop_next)  state_next = BUS_IDLE;
      default:  state_next = BUS_IDLE;
    endcase
  end

`ifdef I2C_GLITCH_COUNT_EN
  // One extra bit of headroom so the +2 case can be detected and clamped.
  assign glitch_sum = {1'b0, glitch_cnt_q}
                    + {{GLITCH_CNT_W{1'b0}}, scl_glitch}
                    + {{GLITCH_CNT_W{1'b0}}, sda_glitch};

  // Saturating count of rejected glitches on either line.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      glitch_cnt_q <= '0;
    end else begin
      glitch_cnt_q <= glitch_sum[GLITCH_CNT_W] ? '1 : glitch_sum[GLITCH_CNT_W-1:0];
    end
  end

  assign bus.glitch_cnt = glitch_cnt_q;
`endif

endmodule

// File: tb/tb_i2c_line_frontend.sv
// tb_i2c_line_frontend
// Self-checking bench for i2c_line_frontend: directed I2C sequences plus random
// pad activity, compared every cycle against a behavioural reference model.
// Builds with or without I2C_GLITCH_COUNT_EN.
module tb_i2c_line_frontend;
  import i2c_pkg::*;

  localparam int SYNC = I2C_SYNC_STAGES;
  localparam int FILT = I2C_FILT_LEN;

  logic clock;
  logic reset;

  i2c_line_frontend_if bif();

  i2c_line_frontend #(.SYNC_STAGES(SYNC), .FILT_LEN(FILT)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int check_count = 0;
  int error_count = 0;

  // Reference model state: pad delay lines, filtered levels, differing-run lengths.
  logic dl_scl[$];
  logic dl_sda[$];
  logic m_filt[2];
  int   m_run[2];
  logic m_busy;
  int   m_gcnt;
  logic e_scl_rise, e_scl_fall, e_start, e_stop;

  int seen_start, seen_stop, seen_scl_fall, seen_scl_rise;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    dl_scl.delete();
    dl_sda.delete();
    for (int i = 0; i < SYNC; i++) begin
      dl_scl.push_back(1'b1);
      dl_sda.push_back(1'b1);
    end
    for (int i = 0; i < 2; i++) begin
      m_filt[i] = 1'b1;
      m_run[i]  = 0;
    end
    m_busy = 1'b0;
    m_gcnt = 0;
    e_scl_rise = 1'b0;
    e_scl_fall = 1'b0;
    e_start    = 1'b0;
    e_stop     = 1'b0;
  endtask

  // A level is accepted once FILT consecutive delayed samples disagree with it;
  // a shorter disagreeing run that ends is a glitch.
  task automatic modelStep();
    logic synced[2];
    logic old_lvl[2];
    int   glitches;
    if (reset !== 1'b1) return;
    synced[0] = dl_scl.pop_front();
    synced[1] = dl_sda.pop_front();
    dl_scl.push_back(bif.SCL_in);
    dl_sda.push_back(bif.SDA_in);
    glitches = 0;
    for (int i = 0; i < 2; i++) begin
      old_lvl[i] = m_filt[i];
      if (synced[i] !== m_filt[i]) begin
        m_run[i]++;
        if (m_run[i] == FILT) begin
          m_filt[i] = ~m_filt[i];
          m_run[i]  = 0;
        end
      end else begin
        if (m_run[i] > 0) glitches++;
        m_run[i] = 0;
      end
    end
    e_scl_rise = m_filt[0] && !old_lvl[0];
    e_scl_fall = !m_filt[0] && old_lvl[0];
    e_start    = old_lvl[0] && m_filt[0] && old_lvl[1] && !m_filt[1];
    e_stop     = old_lvl[0] && m_filt[0] && !old_lvl[1] && m_filt[1];
    if (e_start) m_busy = 1'b1;
    if (e_stop)  m_busy = 1'b0;
    m_gcnt = (m_gcnt + glitches > 255) ? 255 : m_gcnt + glitches;
  endtask

  task automatic compareAll();
    checkOutput("scl_filt",  bif.scl_filt,  m_filt[0]);
    checkOutput("sda_filt",  bif.sda_filt,  m_filt[1]);
    checkOutput("scl_rise",  bif.scl_rise,  e_scl_rise);
    checkOutput("scl_fall",  bif.scl_fall,  e_scl_fall);
    checkOutput("start_det", bif.start_det, e_start);
    checkOutput("stop_det",  bif.stop_det,  e_stop);
    checkOutput("bus_busy",  bif.bus_busy,  m_busy);
`ifdef I2C_GLITCH_COUNT_EN
    checkOutput("glitch_cnt", bif.glitch_cnt, m_gcnt);
`endif
  endtask

  task automatic tick();
    @(posedge clock);
    modelStep();
    @(negedge clock);
    compareAll();
    if (bif.start_det === 1'b1) seen_start++;
    if (bif.stop_det  === 1'b1) seen_stop++;
    if (bif.scl_fall  === 1'b1) seen_scl_fall++;
    if (bif.scl_rise  === 1'b1) seen_scl_rise++;
  endtask

  task automatic clearSeen();
    seen_start = 0;
    seen_stop = 0;
    seen_scl_fall = 0;
    seen_scl_rise = 0;
  endtask

  task automatic applyStimulus(input logic scl, input logic sda, input int cycles);
    bif.SCL_in = scl;
    bif.SDA_in = sda;
    for (int i = 0; i < cycles; i++) tick();
  endtask

  // Hard stop in case something blocks the main sequence.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int g_before;
    clearSeen();
    reset = 1'b0;
    bif.SCL_in = 1'b1;
    bif.SDA_in = 1'b1;
    modelReset();
    applyStimulus(1'b1, 1'b1, 3);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b1, 20);

    // START: measure the edge at which start_det appears.
    bif.SDA_in = 1'b0;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (lat == 0 && bif.start_det === 1'b1) lat = i;
    end
    checkOutput("start_latency", lat, SYNC + FILT);
    checkOutput("busy_after_start", bif.bus_busy, 1'b1);

    // Eight data bits framed by SCL.
    for (int b = 0; b < 8; b++) begin
      applyStimulus(1'b0, bif.SDA_in, 4);
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), 4);
      applyStimulus(1'b1, bif.SDA_in, 6);
    end

    // STOP.
    applyStimulus(1'b0, bif.SDA_in, 4);
    applyStimulus(1'b0, 1'b0, 4);
    applyStimulus(1'b1, 1'b0, 6);
    clearSeen();
    applyStimulus(1'b1, 1'b1, 8);
    checkOutput("stop_count", seen_stop, 1);
    checkOutput("idle_after_stop", bif.bus_busy, 1'b0);

    // Two-cycle low pulse on SCL must be rejected.
    g_before = m_gcnt;
    clearSeen();
    applyStimulus(1'b0, 1'b1, 2);
    applyStimulus(1'b1, 1'b1, 8);
    checkOutput("pulse_no_fall", seen_scl_fall, 0);
    checkOutput("pulse_scl_filt", bif.scl_filt, 1'b1);
`ifdef I2C_GLITCH_COUNT_EN
    checkOutput("pulse_glitch_inc", bif.glitch_cnt - g_before, 1);
`endif

    // Random pad activity, including short pulses and simultaneous changes.
    for (int s = 0; s < 300; s++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 6));
    end

    // Busy bus, then SCL and SDA change in the same cycle.
    applyStimulus(1'b1, 1'b1, 10);
    applyStimulus(1'b1, 1'b0, 8);
    checkOutput("busy_before_simul", bif.bus_busy, 1'b1);
    clearSeen();
    applyStimulus(1'b0, 1'b1, 8);
    checkOutput("simul_fall", seen_scl_fall, 1);
    checkOutput("simul_no_start", seen_start, 0);
    checkOutput("simul_no_stop", seen_stop, 0);
    applyStimulus(1'b1, 1'b1, 6);
    applyStimulus(1'b0, 1'b1, 3);

    // Reset mid-byte: outputs return to reset values at once.
    reset = 1'b0;
    modelReset();
    #1;
    compareAll();
    applyStimulus(1'b1, 1'b1, 3);
    reset = 1'b1;
    clearSeen();
    applyStimulus(1'b1, 1'b1, 20);
    checkOutput("post_reset_busy", bif.bus_busy, 1'b0);
    checkOutput("post_reset_strobes", seen_start + seen_stop + seen_scl_fall + seen_scl_rise, 0);

    // 300 single-cycle SDA glitches with SCL high.
    for (int g = 0; g < 300; g++) begin
      applyStimulus(1'b1, 1'b0, 1);
      applyStimulus(1'b1, 1'b1, 1);
    end
    applyStimulus(1'b1, 1'b1, 6);
    checkOutput("glitch_sda_stable", bif.sda_filt, 1'b1);
`ifdef I2C_GLITCH_COUNT_EN
    checkOutput("glitch_saturated", bif.glitch_cnt, 255);
`endif

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
